demultiplexer_1to4_buffered: RTL

DEMULTIPLEXER_1TO4_BUFFERED -- requirements
Module: demultiplexer_1to4_buffered

---
 rtl/demultiplexer_1to4_buffered.sv | 98 +++++++++
 1 files changed

// File: rtl/demultiplexer_1to4_buffered.sv
// ---------------------------------------------------------------------------
// demultiplexer_1to4_buffered
//
// Routes one valid/ready input stream to one of four output channels. Each
// output channel has a one-entry skid-free register holding a data word, a
// valid flag and a counter of completed output transfers.
//
// Parameters
//   WIDTH      data width of the input and of each output channel
//   CNT_WIDTH  width of each per-channel transfer counter (wraps)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    word to be routed
//   in_select  destination channel 0..3 (sampled only when in_valid=1)
//   in_valid   in_data/in_select are valid
//   in_ready   selected channel can take a word this cycle (combinational)
//   out_data   channel k data on [k*WIDTH +: WIDTH]
//   out_valid  channel k valid on bit k
//   out_ready  channel k downstream ready on bit k
//   out_count  channel k transfer count on [k*CNT_WIDTH +: CNT_WIDTH]
// ---------------------------------------------------------------------------
module demultiplexer_1to4_buffered #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [1:0]             in_select,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4*WIDTH-1:0]     out_data,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready,
  output logic [4*CNT_WIDTH-1:0] out_count
);

  localparam int NUM_CH = 4;

  logic [NUM_CH-1:0][WIDTH-1:0]     data_q,  data_d;
  logic [NUM_CH-1:0]                valid_q, valid_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic              in_fire;
  logic [NUM_CH-1:0] out_fire;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    // A full channel can still accept when it drains in the same cycle, so
    // a streaming channel never inserts a bubble. in_valid is deliberately
    // not part of this term.
    in_ready = !valid_q[in_select] || out_ready[in_select];
    in_fire  = in_valid && in_ready;
    out_fire = valid_q & out_ready;

    for (int k = 0; k < NUM_CH; k++) begin
      if (out_fire[k]) begin
        valid_d[k] = 1'b0;
        cnt_d[k]   = cnt_q[k] + 1'b1;
      end
    end

    // Applied after the drain so a same-cycle refill keeps the channel valid.
    if (in_fire) begin
      data_d[in_select]  = in_data;
      valid_d[in_select] = 1'b1;
    end
  end

  // NOTE: the data registers are reset too, because out_data must read zero
  // while rst is high; storage that is only qualified by valid would not need it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Packed [ch][bit] arrays flatten with channel k at [k*W +: W].
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_count = cnt_q;

endmodule
